// File: rtl/aww_types_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, stall causes,
// reset values and a small mask helper.
package aww_types_pkg;

   typedef enum logic [1:0] {
      RUN,
      LU_BUBBLE,
      MEM_WAIT,
      HALT
   } hz_state_t;

   typedef enum logic [2:0] {
      CAUSE_NONE,
      CAUSE_LU,
      CAUSE_MEM,
      CAUSE_BR,
      CAUSE_FETCH,
      CAUSE_HALT
   } hz_cause_t;

   // Bubble counter is wide enough for the largest legal load latency (7).
   localparam int CNT_BITS = 3;

   localparam hz_state_t           RST_STATE = RUN;
   localparam logic [CNT_BITS-1:0] RST_CNT   = '0;

   function automatic logic [7:0] low_mask(input int n);
      return 8'((1 << n) - 1);
   endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Event counter with synchronous clear; SAT=1 holds at all-ones, SAT=0 wraps.
module hazard_perf_cnt #(
   parameter int CNT_W = 16,
   parameter bit SAT   = 1'b0
) (
   input  logic             clk_i,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && !(SAT && (&count_q))) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Pipeline hazard controller: load-use bubbles, data-memory waits, branch flushes, halt.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl_pipe
   import aww_types_pkg::*;
#(
   parameter int NREG       = 4,
   parameter int REG_W      = 5,
   parameter int LOAD_LAT   = 1,
   parameter int BR_PENALTY = 1,
   parameter int CNT_W      = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             exmem_dreq,
   input  logic             idex_dread,
   input  logic [REG_W-1:0] idex_rt,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             npc_change,
   input  logic             idex_halt,
   input  logic [NREG-1:0]  flush_req,
   output logic [NREG-1:0]  pipe_en,
   output logic [NREG-1:0]  pipe_flush,
   output logic             pc_wen,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [NREG-1:0] ALL_ONES = {NREG{1'b1}};
   localparam logic [NREG-1:0] BIT0     = NREG'(1);
   localparam logic [NREG-1:0] BIT1     = NREG'(2);
   localparam logic [NREG-1:0] BR_MASK  = NREG'(low_mask(BR_PENALTY));

   hz_state_t           state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                halted_q;

   logic                luHazard;
   logic                memStall;
   hz_cause_t           runCause;
   hz_cause_t           cause;
   logic [NREG-1:0]     enRaw;
   logic [NREG-1:0]     flushRaw;
   logic                pcRaw;

   // Register 0 is hardwired, so a load targeting it never creates a hazard.
   always_comb begin
      luHazard = idex_dread && (idex_rt != '0) &&
                 ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
      memStall = exmem_dreq && !dhit;
      if (luHazard) begin
         runCause = CAUSE_LU;
      end else if (npc_change) begin
         runCause = CAUSE_BR;
      end else if (!ihit) begin
         runCause = CAUSE_FETCH;
      end else begin
         runCause = CAUSE_NONE;
      end
   end

   // A memory wait inside a bubble freezes everything and holds the bubble count.
   always_comb begin
      cause   = CAUSE_NONE;
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (idex_halt) begin
               cause   = CAUSE_HALT;
               state_d = HALT;
            end else if (memStall) begin
               cause   = CAUSE_MEM;
               state_d = MEM_WAIT;
            end else begin
               cause = runCause;
            end
         end
         MEM_WAIT: begin
            if (!dhit) begin
               cause = CAUSE_MEM;
            end else begin
               cause   = runCause;
               state_d = RUN;
            end
         end
         LU_BUBBLE: begin
            if (memStall) begin
               cause = CAUSE_MEM;
            end else begin
               cause = CAUSE_LU;
               cnt_d = cnt_q - CNT_BITS'(1);
               if (cnt_q == CNT_BITS'(1)) begin
                  state_d = RUN;
               end
            end
         end
         HALT: begin
            cause = CAUSE_HALT;
         end
         default: begin
            state_d = RUN;
         end
      endcase
      if ((state_q == RUN || state_q == MEM_WAIT) && cause == CAUSE_LU && LOAD_LAT > 1) begin
         cnt_d   = CNT_BITS'(LOAD_LAT - 1);
         state_d = LU_BUBBLE;
      end
   end

   // On the halt-entry cycle the decode slot is squashed; once halted everything freezes.
   always_comb begin
      enRaw    = '0;
      flushRaw = '0;
      pcRaw    = 1'b0;
      case (cause)
         CAUSE_NONE: begin
            enRaw = ALL_ONES;
            pcRaw = 1'b1;
         end
         CAUSE_LU: begin
            enRaw    = ALL_ONES & ~BIT0;
            flushRaw = BIT1;
         end
         CAUSE_BR: begin
            enRaw    = ALL_ONES;
            flushRaw = BR_MASK;
            pcRaw    = ihit;
         end
         CAUSE_HALT: begin
            if (state_q == RUN) begin
               enRaw    = ALL_ONES & ~BIT0;
               flushRaw = BIT0;
            end
         end
         default: begin
         end
      endcase
      if (!nRST) begin
         pipe_en    = '0;
         pipe_flush = ALL_ONES;
         pc_wen     = 1'b0;
      end else begin
         pipe_en    = enRaw;
         pipe_flush = flushRaw | flush_req;
         pc_wen     = pcRaw;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= RST_STATE;
         cnt_q    <= RST_CNT;
         halted_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_d == HALT) begin
            halted_q <= 1'b1;
         end
      end
   end

   assign halted = halted_q & nRST;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   hazard_perf_cnt #(.CNT_W(CNT_W), .SAT(1'b1)) uStallCnt (
      .clk_i   (CLK),
      .clear_i (!nRST),
      .inc_i   (!pc_wen),
      .count_o (stallCnt)
   );

   hazard_perf_cnt #(.CNT_W(CNT_W), .SAT(1'b0)) uFlushCnt (
      .clk_i   (CLK),
      .clear_i (!nRST),
      .inc_i   (cause == CAUSE_BR),
      .count_o (flushCnt)
   );

   assign stall_cycles = nRST ? stallCnt : '0;
   assign flush_count  = nRST ? flushCnt : '0;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Scoreboard bench for hazard_ctrl_pipe (NREG=4, LOAD_LAT=3, BR_PENALTY=2).
// Counter expectations follow HAZARD_PERF_EN the same way the design does.
module tb_hazard_ctrl_pipe;

   localparam int NREG       = 4;
   localparam int REG_W      = 5;
   localparam int LOAD_LAT   = 3;
   localparam int BR_PENALTY = 2;
   localparam int CNT_W      = 16;

`ifdef HAZARD_PERF_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             nRST;
   logic             ihit, dhit, exmem_dreq, idex_dread;
   logic [REG_W-1:0] idex_rt, ifid_rs, ifid_rt;
   logic             npc_change, idex_halt;
   logic [NREG-1:0]  flush_req;
   logic [NREG-1:0]  pipe_en, pipe_flush;
   logic             pc_wen, halted;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   hazard_ctrl_pipe #(
      .NREG(NREG), .REG_W(REG_W), .LOAD_LAT(LOAD_LAT),
      .BR_PENALTY(BR_PENALTY), .CNT_W(CNT_W)
   ) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .exmem_dreq(exmem_dreq), .idex_dread(idex_dread), .idex_rt(idex_rt),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .npc_change(npc_change),
      .idex_halt(idex_halt), .flush_req(flush_req), .pipe_en(pipe_en),
      .pipe_flush(pipe_flush), .pc_wen(pc_wen), .halted(halted),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       nrst, ihit, dreq, dhit, dread;
      logic [4:0] rt, rs, rtb;
      logic       npc, halt;
      logic [3:0] freq;
   } stim_t;

   typedef struct packed {
      logic [3:0] en, enCare, flush;
      logic       pcwen, halted, brEv;
   } exp_t;

   exp_t        sb[$];
   int          nChecks = 0;
   int          nFails  = 0;
   int unsigned expStall = 0;
   logic [15:0] expFlush = '0;

   function automatic stim_t st(logic nrst, logic ih, logic dreq, logic dh, logic dread,
                                logic [4:0] rt, logic [4:0] rs, logic [4:0] rtb,
                                logic npc, logic halt, logic [3:0] freq);
      return '{nrst, ih, dreq, dh, dread, rt, rs, rtb, npc, halt, freq};
   endfunction

   function automatic stim_t idle();
      return st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
   endfunction

   function automatic exp_t ex(logic [3:0] en, logic [3:0] fl, logic pc, logic hl,
                               logic br = 1'b0, logic [3:0] care = 4'hF);
      return '{en, care, fl, pc, hl, br};
   endfunction

   task automatic applyStimulus(input stim_t s);
      nRST       = s.nrst;
      ihit       = s.ihit;
      exmem_dreq = s.dreq;
      dhit       = s.dhit;
      idex_dread = s.dread;
      idex_rt    = s.rt;
      ifid_rs    = s.rs;
      ifid_rt    = s.rtb;
      npc_change = s.npc;
      idex_halt  = s.halt;
      flush_req  = s.freq;
   endtask

   task automatic scoreExpected(input stim_t s, input exp_t e);
      sb.push_back(e);
      if (!s.nrst) begin
         expStall = 0;
         expFlush = '0;
      end else begin
         if (!e.pcwen) expStall++;
         if (e.brEv) expFlush++;
      end
   endtask

   task automatic test_reset();
      stim_t s[$];
      exp_t  e[$];
      exp_t  w;
      logic [15:0] wantS, wantF;
      s.push_back(st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0)); e.push_back(ex(4'h0, 4'hF, 0, 0));
      s.push_back(st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0)); e.push_back(ex(4'h0, 4'hF, 0, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hF, 4'h0, 1, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hF, 4'h0, 1, 0));
      @(posedge CLK); #1;
      foreach (s[i]) begin
         applyStimulus(s[i]);
         scoreExpected(s[i], e[i]);
         @(negedge CLK);
         w = sb.pop_front();
         nChecks++;
         if (((pipe_en & w.enCare) !== (w.en & w.enCare)) || pipe_flush !== w.flush ||
             pc_wen !== w.pcwen || halted !== w.halted) begin
            nFails++;
            $display("[TB] FAIL reset[%0d]: got en=%b flush=%b pc_wen=%b halted=%b, want en=%b flush=%b pc_wen=%b halted=%b",
                     i, pipe_en, pipe_flush, pc_wen, halted, w.en, w.flush, w.pcwen, w.halted);
         end
         @(posedge CLK); #1;
      end
      wantS = PERF_ON ? 16'(expStall) : 16'd0;
      wantF = PERF_ON ? expFlush : 16'd0;
      nChecks++;
      if (stall_cycles !== wantS || flush_count !== wantF) begin
         nFails++;
         $display("[TB] FAIL reset_counters: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                  stall_cycles, flush_count, wantS, wantF);
      end
   endtask

   task automatic test_load_use();
      stim_t s[$];
      exp_t  e[$];
      exp_t  w;
      logic [15:0] wantS;
      s.push_back(st(1, 1, 0, 0, 1, 5, 5, 0, 0, 0, 4'h0)); e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hF, 4'h0, 1, 0));
      s.push_back(st(1, 1, 0, 0, 1, 7, 3, 7, 0, 0, 4'h0)); e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(st(1, 1, 0, 0, 1, 7, 3, 7, 0, 0, 4'h0)); e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(st(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0)); e.push_back(ex(4'h0, 4'h0, 0, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hF, 4'h0, 1, 0));
      foreach (s[i]) begin
         applyStimulus(s[i]);
         scoreExpected(s[i], e[i]);
         @(negedge CLK);
         w = sb.pop_front();
         nChecks++;
         if (((pipe_en & w.enCare) !== (w.en & w.enCare)) || pipe_flush !== w.flush ||
             pc_wen !== w.pcwen || halted !== w.halted) begin
            nFails++;
            $display("[TB] FAIL load_use[%0d]: got en=%b flush=%b pc_wen=%b halted=%b, want en=%b flush=%b pc_wen=%b halted=%b",
                     i, pipe_en, pipe_flush, pc_wen, halted, w.en, w.flush, w.pcwen, w.halted);
         end
         @(posedge CLK); #1;
      end
      wantS = PERF_ON ? 16'(expStall) : 16'd0;
      nChecks++;
      if (stall_cycles !== wantS) begin
         nFails++;
         $display("[TB] FAIL load_use_stalls: got %0d, want %0d", stall_cycles, wantS);
      end
   endtask

   task automatic test_reg0();
      stim_t s[$];
      exp_t  e[$];
      exp_t  w;
      s.push_back(st(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0)); e.push_back(ex(4'hF, 4'h0, 1, 0));
      s.push_back(st(1, 1, 0, 0, 1, 5, 6, 7, 0, 0, 4'h0)); e.push_back(ex(4'hF, 4'h0, 1, 0));
      s.push_back(st(1, 1, 0, 0, 0, 5, 5, 5, 0, 0, 4'h0)); e.push_back(ex(4'hF, 4'h0, 1, 0));
      foreach (s[i]) begin
         applyStimulus(s[i]);
         scoreExpected(s[i], e[i]);
         @(negedge CLK);
         w = sb.pop_front();
         nChecks++;
         if (((pipe_en & w.enCare) !== (w.en & w.enCare)) || pipe_flush !== w.flush ||
             pc_wen !== w.pcwen || halted !== w.halted) begin
            nFails++;
            $display("[TB] FAIL no_hazard[%0d]: got en=%b flush=%b pc_wen=%b halted=%b, want en=%b flush=%b pc_wen=%b halted=%b",
                     i, pipe_en, pipe_flush, pc_wen, halted, w.en, w.flush, w.pcwen, w.halted);
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_mem_wait();
      stim_t s[$];
      exp_t  e[$];
      exp_t  w;
      logic [15:0] wantS;
      s.push_back(st(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0)); e.push_back(ex(4'h0, 4'h0, 0, 0));
      s.push_back(st(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0)); e.push_back(ex(4'h0, 4'h0, 0, 0));
      s.push_back(st(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h8)); e.push_back(ex(4'h0, 4'h8, 0, 0));
      s.push_back(st(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0)); e.push_back(ex(4'h0, 4'h0, 0, 0));
      s.push_back(st(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4'h0)); e.push_back(ex(4'hF, 4'h0, 1, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hF, 4'h0, 1, 0));
      s.push_back(st(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0)); e.push_back(ex(4'h0, 4'h0, 0, 0));
      s.push_back(st(1, 1, 1, 1, 1, 5, 5, 0, 0, 0, 4'h0)); e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hF, 4'h0, 1, 0));
      s.push_back(st(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4'h0)); e.push_back(ex(4'hF, 4'h0, 1, 0));
      foreach (s[i]) begin
         applyStimulus(s[i]);
         scoreExpected(s[i], e[i]);
         @(negedge CLK);
         w = sb.pop_front();
         nChecks++;
         if (((pipe_en & w.enCare) !== (w.en & w.enCare)) || pipe_flush !== w.flush ||
             pc_wen !== w.pcwen || halted !== w.halted) begin
            nFails++;
            $display("[TB] FAIL mem_wait[%0d]: got en=%b flush=%b pc_wen=%b halted=%b, want en=%b flush=%b pc_wen=%b halted=%b",
                     i, pipe_en, pipe_flush, pc_wen, halted, w.en, w.flush, w.pcwen, w.halted);
         end
         @(posedge CLK); #1;
      end
      wantS = PERF_ON ? 16'(expStall) : 16'd0;
      nChecks++;
      if (stall_cycles !== wantS) begin
         nFails++;
         $display("[TB] FAIL mem_wait_stalls: got %0d, want %0d", stall_cycles, wantS);
      end
   endtask

   task automatic test_branch();
      stim_t s[$];
      exp_t  e[$];
      exp_t  w;
      logic [15:0] wantS, wantF;
      s.push_back(st(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0)); e.push_back(ex(4'hF, 4'h3, 1, 0, 1));
      s.push_back(idle());                                  e.push_back(ex(4'hF, 4'h0, 1, 0));
      s.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0)); e.push_back(ex(4'hF, 4'h3, 0, 0, 1));
      s.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0)); e.push_back(ex(4'h0, 4'h0, 0, 0));
      s.push_back(st(1, 1, 0, 0, 1, 5, 5, 0, 1, 0, 4'h0)); e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(st(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0)); e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(st(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0)); e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(st(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0)); e.push_back(ex(4'hF, 4'h3, 1, 0, 1));
      s.push_back(st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h4)); e.push_back(ex(4'hF, 4'h4, 1, 0));
      foreach (s[i]) begin
         applyStimulus(s[i]);
         scoreExpected(s[i], e[i]);
         @(negedge CLK);
         w = sb.pop_front();
         nChecks++;
         if (((pipe_en & w.enCare) !== (w.en & w.enCare)) || pipe_flush !== w.flush ||
             pc_wen !== w.pcwen || halted !== w.halted) begin
            nFails++;
            $display("[TB] FAIL branch[%0d]: got en=%b flush=%b pc_wen=%b halted=%b, want en=%b flush=%b pc_wen=%b halted=%b",
                     i, pipe_en, pipe_flush, pc_wen, halted, w.en, w.flush, w.pcwen, w.halted);
         end
         @(posedge CLK); #1;
      end
      wantS = PERF_ON ? 16'(expStall) : 16'd0;
      wantF = PERF_ON ? expFlush : 16'd0;
      nChecks++;
      if (flush_count !== wantF) begin
         nFails++;
         $display("[TB] FAIL branch_flush_count: got %0d, want %0d", flush_count, wantF);
      end
      nChecks++;
      if (stall_cycles !== wantS) begin
         nFails++;
         $display("[TB] FAIL branch_stalls: got %0d, want %0d", stall_cycles, wantS);
      end
   endtask

   task automatic test_halt();
      stim_t s[$];
      exp_t  e[$];
      exp_t  w;
      logic [15:0] wantS, wantF;
      s.push_back(st(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4'h0)); e.push_back(ex(4'h0, 4'h1, 0, 0, 0, 4'h0));
      s.push_back(idle());                                  e.push_back(ex(4'h0, 4'h0, 0, 1));
      s.push_back(st(1, 1, 0, 0, 1, 5, 5, 0, 1, 0, 4'h0)); e.push_back(ex(4'h0, 4'h0, 0, 1));
      s.push_back(st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h4)); e.push_back(ex(4'h0, 4'h4, 0, 1));
      s.push_back(idle());                                  e.push_back(ex(4'h0, 4'h0, 0, 1));
      foreach (s[i]) begin
         applyStimulus(s[i]);
         scoreExpected(s[i], e[i]);
         @(negedge CLK);
         w = sb.pop_front();
         nChecks++;
         if (((pipe_en & w.enCare) !== (w.en & w.enCare)) || pipe_flush !== w.flush ||
             pc_wen !== w.pcwen || halted !== w.halted) begin
            nFails++;
            $display("[TB] FAIL halt[%0d]: got en=%b flush=%b pc_wen=%b halted=%b, want en=%b flush=%b pc_wen=%b halted=%b",
                     i, pipe_en, pipe_flush, pc_wen, halted, w.en, w.flush, w.pcwen, w.halted);
         end
         @(posedge CLK); #1;
      end
      wantS = PERF_ON ? 16'(expStall) : 16'd0;
      wantF = PERF_ON ? expFlush : 16'd0;
      nChecks++;
      if (stall_cycles !== wantS || flush_count !== wantF) begin
         nFails++;
         $display("[TB] FAIL halt_counters: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                  stall_cycles, flush_count, wantS, wantF);
      end
   endtask

   task automatic test_reset_mid_bubble();
      stim_t s[$];
      exp_t  e[$];
      exp_t  w;
      logic [15:0] wantS, wantF;
      s.push_back(st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0)); e.push_back(ex(4'h0, 4'hF, 0, 0));
      s.push_back(st(1, 1, 0, 0, 1, 9, 9, 0, 0, 0, 4'h0)); e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hE, 4'h2, 0, 0));
      s.push_back(st(0, 1, 0, 0, 1, 9, 9, 0, 1, 0, 4'h8)); e.push_back(ex(4'h0, 4'hF, 0, 0));
      s.push_back(st(0, 1, 0, 0, 1, 9, 9, 0, 1, 0, 4'h8)); e.push_back(ex(4'h0, 4'hF, 0, 0));
      s.push_back(st(0, 1, 0, 0, 1, 9, 9, 0, 1, 0, 4'h8)); e.push_back(ex(4'h0, 4'hF, 0, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hF, 4'h0, 1, 0));
      s.push_back(idle());                                  e.push_back(ex(4'hF, 4'h0, 1, 0));
      foreach (s[i]) begin
         applyStimulus(s[i]);
         scoreExpected(s[i], e[i]);
         @(negedge CLK);
         w = sb.pop_front();
         nChecks++;
         if (((pipe_en & w.enCare) !== (w.en & w.enCare)) || pipe_flush !== w.flush ||
             pc_wen !== w.pcwen || halted !== w.halted) begin
            nFails++;
            $display("[TB] FAIL reset_mid_bubble[%0d]: got en=%b flush=%b pc_wen=%b halted=%b, want en=%b flush=%b pc_wen=%b halted=%b",
                     i, pipe_en, pipe_flush, pc_wen, halted, w.en, w.flush, w.pcwen, w.halted);
         end
         @(posedge CLK); #1;
      end
      wantS = PERF_ON ? 16'(expStall) : 16'd0;
      wantF = PERF_ON ? expFlush : 16'd0;
      nChecks++;
      if (stall_cycles !== wantS || flush_count !== wantF) begin
         nFails++;
         $display("[TB] FAIL reset_mid_bubble_counters: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                  stall_cycles, flush_count, wantS, wantF);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyStimulus(st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0));
      test_reset();
      test_load_use();
      test_reg0();
      test_mem_wait();
      test_branch();
      test_halt();
      test_reset_mid_bubble();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
